// File: rtl/icb_master_wb.sv
// icb_master_wb: ICB write initiator that drains the accelerator's 64-bit
// output SRAM to system memory. Each SRAM word becomes two 32-bit ICB
// writes (low half at dst+8*i, high half at dst+8*i+4). Only one ICB
// transaction is ever outstanding.
module icb_master_wb #(
  parameter int SRAM_AW = 12,
  parameter int LEN_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SRAM_AW-1:0] src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               csbn_sram_output,
  output logic [SRAM_AW-1:0] raddr_sram_output,
  input  logic [63:0]        rdata_sram_output,
  output logic               icb_cmd_valid,
  input  logic               icb_cmd_ready,
  output logic               icb_cmd_read,
  output logic [31:0]        icb_cmd_addr,
  output logic [31:0]        icb_cmd_wdata,
  output logic [3:0]         icb_cmd_wmask,
  input  logic               icb_rsp_valid,
  output logic               icb_rsp_ready,
  input  logic [31:0]        icb_rsp_rdata,
  input  logic               icb_rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAT,
    S_CMD_LO,
    S_RSP_LO,
    S_CMD_HI,
    S_RSP_HI,
    S_DONE
  } state_t;

  state_t             state_reg;
  logic [SRAM_AW-1:0] src_reg;
  logic [31:0]        dst_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [LEN_W-1:0]   cnt_reg;
  // The low half of each SRAM word goes straight into icb_cmd_wdata when
  // it is captured, so only the high half needs to be buffered.
  logic [31:0]        hi_buf_reg;

  logic [LEN_W-1:0]   cnt_inc;
  logic [31:0]        word_off;
  logic               last_word;
  logic               unused_rsp_rdata;

  assign cnt_inc   = cnt_reg + LEN_W'(1);
  assign word_off  = 32'(cnt_reg) << 3;
  assign last_word = (cnt_reg == len_reg - LEN_W'(1));

  // Write-only initiator: read data on the response channel carries nothing.
  assign unused_rsp_rdata = ^icb_rsp_rdata;

  assign icb_cmd_read  = 1'b0;
  assign icb_cmd_wmask = 4'hF;

  // Transfer sequencer; every output is registered and set on the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= S_IDLE;
      src_reg           <= '0;
      dst_reg           <= '0;
      len_reg           <= '0;
      cnt_reg           <= '0;
      hi_buf_reg        <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      csbn_sram_output  <= 1'b1;
      raddr_sram_output <= '0;
      icb_cmd_valid     <= 1'b0;
      icb_cmd_addr      <= '0;
      icb_cmd_wdata     <= '0;
      icb_rsp_ready     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            src_reg <= src_addr;
            dst_reg <= dst_addr;
            len_reg <= len;
            cnt_reg <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
            if (len == '0) begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              csbn_sram_output  <= 1'b0;
              raddr_sram_output <= src_addr;
              state_reg         <= S_RD;
            end
          end
        end

        S_RD: begin
          csbn_sram_output <= 1'b1;
          state_reg        <= S_LAT;
        end

        S_LAT: begin
          hi_buf_reg    <= rdata_sram_output[63:32];
          icb_cmd_valid <= 1'b1;
          icb_cmd_addr  <= dst_reg + word_off;
          icb_cmd_wdata <= rdata_sram_output[31:0];
          state_reg     <= S_CMD_LO;
        end

        S_CMD_LO: begin
          if (icb_cmd_ready) begin
            icb_cmd_valid <= 1'b0;
            icb_rsp_ready <= 1'b1;
            state_reg     <= S_RSP_LO;
          end
        end

        S_RSP_LO: begin
          if (icb_rsp_valid) begin
            icb_rsp_ready <= 1'b0;
            if (icb_rsp_err) begin
              err       <= 1'b1;
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              icb_cmd_valid <= 1'b1;
              icb_cmd_addr  <= dst_reg + word_off + 32'd4;
              icb_cmd_wdata <= hi_buf_reg;
              state_reg     <= S_CMD_HI;
            end
          end
        end

        S_CMD_HI: begin
          if (icb_cmd_ready) begin
            icb_cmd_valid <= 1'b0;
            icb_rsp_ready <= 1'b1;
            state_reg     <= S_RSP_HI;
          end
        end

        S_RSP_HI: begin
          if (icb_rsp_valid) begin
            icb_rsp_ready <= 1'b0;
            if (icb_rsp_err || last_word) begin
              err       <= err | icb_rsp_err;
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              cnt_reg           <= cnt_inc;
              csbn_sram_output  <= 1'b0;
              raddr_sram_output <= src_reg + SRAM_AW'(cnt_inc);
              state_reg         <= S_RD;
            end
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icb_master_wb.sv
// Testbench for icb_master_wb: behavioural SRAM and ICB slave with
// configurable stalls and error injection, checked against a transfer-level
// model of the expected write sequence.
module tb_icb_master_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] src_addr;
  logic [31:0] dst_addr;
  logic [11:0] len;
  logic        busy, done, err;
  logic        csbn_sram_output;
  logic [11:0] raddr_sram_output;
  logic [63:0] rdata_sram_output;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [31:0] icb_rsp_rdata;

  always #5 clk = ~clk;

  icb_master_wb #(.SRAM_AW(12), .LEN_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
    .csbn_sram_output(csbn_sram_output), .raddr_sram_output(raddr_sram_output),
    .rdata_sram_output(rdata_sram_output),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] sram [4096];
  logic [68:0] log_q [$];   // {read, wmask, addr, wdata} of accepted commands
  logic [68:0] exp_q [$];
  logic [11:0] rd_q  [$];   // SRAM addresses read
  logic [11:0] exp_rd [$];
  logic        exp_err;

  int stall_cycles = 0;
  int err_at       = -1;
  int resp_idx     = 0;
  int done_cnt     = 0;
  int proto_err    = 0;

  int          rsp_stage = 0;
  bit          holding   = 0;
  int          wait_cnt  = 0;
  logic [31:0] hold_addr, hold_wdata;
  bit          sram_pend = 0;
  logic [63:0] sram_pend_data;

  // SRAM and ICB slave models plus protocol monitors, all driven on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      icb_cmd_ready = 1'b0;
      icb_rsp_valid = 1'b0;
      icb_rsp_err   = 1'b0;
      rsp_stage     = 0;
      holding       = 0;
      wait_cnt      = 0;
      sram_pend     = 0;
    end else begin
      // SRAM: data valid only during the cycle after the select cycle
      rdata_sram_output = sram_pend ? sram_pend_data : {$urandom, $urandom};
      sram_pend = !csbn_sram_output;
      if (!csbn_sram_output) begin
        sram_pend_data = sram[raddr_sram_output];
        rd_q.push_back(raddr_sram_output);
      end
      if (done) done_cnt++;
      if (icb_cmd_valid && icb_rsp_ready) proto_err++;
      // ICB slave
      if (rsp_stage == 2) begin
        icb_rsp_valid = 1'b0;
        icb_rsp_err   = 1'b0;
        rsp_stage     = 0;
      end
      if (rsp_stage == 1) begin
        icb_cmd_ready = 1'b0;
        icb_rsp_valid = 1'b1;
        icb_rsp_rdata = $urandom;
        icb_rsp_err   = (resp_idx == err_at);
        resp_idx++;
        if (!icb_rsp_ready) proto_err++;
        rsp_stage = 2;
      end else if (icb_cmd_valid) begin
        if (!holding) begin
          holding    = 1;
          hold_addr  = icb_cmd_addr;
          hold_wdata = icb_cmd_wdata;
          wait_cnt   = 0;
        end else if (icb_cmd_addr !== hold_addr || icb_cmd_wdata !== hold_wdata) begin
          proto_err++;
        end
        if (wait_cnt < stall_cycles) begin
          icb_cmd_ready = 1'b0;
          wait_cnt++;
        end else begin
          icb_cmd_ready = 1'b1;
          log_q.push_back({icb_cmd_read, icb_cmd_wmask, icb_cmd_addr, icb_cmd_wdata});
          holding   = 0;
          rsp_stage = 1;
        end
      end else begin
        icb_cmd_ready = 1'b0;
        if (holding) proto_err++;
      end
    end
  end

  // Reference: the write sequence a transfer must produce, truncated at the failing response
  function automatic void build_exp(input logic [11:0] s, input logic [31:0] d,
                                    input int l, input int e_at);
    logic [63:0] word;
    logic [31:0] a;
    exp_q.delete();
    exp_rd.delete();
    exp_err = 1'b0;
    for (int w = 0; w < l; w++) begin
      exp_rd.push_back(12'((int'(s) + w) % 4096));
      word = sram[(int'(s) + w) % 4096];
      a = d + 32'(8 * w);
      exp_q.push_back({1'b0, 4'hF, a, word[31:0]});
      if (exp_q.size() - 1 == e_at) begin exp_err = 1'b1; break; end
      exp_q.push_back({1'b0, 4'hF, a + 32'd4, word[63:32]});
      if (exp_q.size() - 1 == e_at) begin exp_err = 1'b1; break; end
    end
  endfunction

  // Launch one transfer and wait (bounded) for done; extra_at pulses a second start while busy
  task automatic run_xfer(input logic [11:0] s, input logic [31:0] d, input logic [11:0] l,
                          input int extra_at, output int first_cmd, output int done_at);
    int n;
    @(negedge clk);
    log_q.delete();
    rd_q.delete();
    done_cnt  = 0;
    proto_err = 0;
    resp_idx  = 0;
    src_addr  = s;
    dst_addr  = d;
    len       = l;
    start     = 1'b1;
    first_cmd = -1;
    done_at   = -1;
    n = 0;
    while (done_at < 0 && n < 3000) begin
      @(negedge clk);
      n++;
      start = (n == extra_at);
      if (start) begin
        src_addr = ~s;
        dst_addr = d + 32'h1000;
        len      = l + 12'd1;
      end
      #1;
      if (icb_cmd_valid && first_cmd < 0) first_cmd = n;
      if (done) done_at = n;
    end
    start = 1'b0;
    total++;
    if (done_at < 0) begin
      $display("FAIL xfer_timeout got=no_done want=done");
      bad++;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b want=0", busy); bad++; end
    total++; if (done !== 1'b0) begin $display("FAIL reset_done got=%b want=0", done); bad++; end
    total++; if (err !== 1'b0) begin $display("FAIL reset_err got=%b want=0", err); bad++; end
    total++; if (csbn_sram_output !== 1'b1) begin $display("FAIL reset_csbn got=%b want=1", csbn_sram_output); bad++; end
    total++; if (raddr_sram_output !== 12'h0) begin $display("FAIL reset_raddr got=%h want=0", raddr_sram_output); bad++; end
    total++; if (icb_cmd_valid !== 1'b0) begin $display("FAIL reset_cmd_valid got=%b want=0", icb_cmd_valid); bad++; end
    total++; if (icb_cmd_addr !== 32'h0 || icb_cmd_wdata !== 32'h0) begin
      $display("FAIL reset_cmd_bus got=%h/%h want=0/0", icb_cmd_addr, icb_cmd_wdata); bad++; end
    total++; if (icb_rsp_ready !== 1'b0) begin $display("FAIL reset_rsp_ready got=%b want=0", icb_rsp_ready); bad++; end
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset checked");
  endtask

  task automatic test_single();
    int fc, da;
    sram[5] = 64'h11223344_55667788;
    stall_cycles = 0; err_at = -1;
    build_exp(12'h005, 32'h1000_0000, 1, -1);
    run_xfer(12'h005, 32'h1000_0000, 12'd1, -1, fc, da);
    total++; if (log_q.size() != 2) begin $display("FAIL single_count got=%0d want=2", log_q.size()); bad++; end
    foreach (exp_q[k]) if (k < log_q.size()) begin
      total++; if (log_q[k] !== exp_q[k]) begin $display("FAIL single_txn[%0d] got=%h want=%h", k, log_q[k], exp_q[k]); bad++; end
    end
    total++; if (fc != 3) begin $display("FAIL single_first_cmd got=%0d want=3", fc); bad++; end
    total++; if (da != 7) begin $display("FAIL single_done_cycle got=%0d want=7", da); bad++; end
    total++; if (done_cnt != 1) begin $display("FAIL single_done_pulses got=%0d want=1", done_cnt); bad++; end
    total++; if (busy !== 1'b0 || err !== 1'b0) begin $display("FAIL single_idle got=busy%b/err%b want=0/0", busy, err); bad++; end
    $display("test_single writes=%0d done_cycle=%0d", log_q.size(), da);
  endtask

  task automatic test_stall();
    int fc, da;
    logic [11:0] s;
    s = 12'($urandom);
    stall_cycles = 4; err_at = -1;
    build_exp(s, 32'h2000_0100, 3, -1);
    run_xfer(s, 32'h2000_0100, 12'd3, -1, fc, da);
    total++; if (log_q.size() != 6) begin $display("FAIL stall_count got=%0d want=6", log_q.size()); bad++; end
    foreach (exp_q[k]) if (k < log_q.size()) begin
      total++; if (log_q[k] !== exp_q[k]) begin $display("FAIL stall_txn[%0d] got=%h want=%h", k, log_q[k], exp_q[k]); bad++; end
    end
    total++; if (proto_err != 0) begin $display("FAIL stall_protocol got=%0d want=0", proto_err); bad++; end
    total++; if (da != 43) begin $display("FAIL stall_done_cycle got=%0d want=43", da); bad++; end
    $display("test_stall src=%h writes=%0d done_cycle=%0d", s, log_q.size(), da);
  endtask

  task automatic test_zero_len();
    int fc, da;
    stall_cycles = 0; err_at = -1;
    run_xfer(12'h123, 32'h3000_0000, 12'd0, -1, fc, da);
    total++; if (fc != -1 || log_q.size() != 0) begin $display("FAIL zero_cmd got=%0d want=-1", fc); bad++; end
    total++; if (da < 1 || da > 2) begin $display("FAIL zero_done_cycle got=%0d want=1..2", da); bad++; end
    total++; if (done_cnt != 1 || err !== 1'b0) begin $display("FAIL zero_done_err got=%0d/%b want=1/0", done_cnt, err); bad++; end
    $display("test_zero_len done_cycle=%0d", da);
  endtask

  task automatic test_bus_err();
    int fc, da;
    stall_cycles = 1; err_at = 2;
    build_exp(12'h040, 32'h4000_0000, 4, 2);
    run_xfer(12'h040, 32'h4000_0000, 12'd4, -1, fc, da);
    total++; if (log_q.size() != 3) begin $display("FAIL err_count got=%0d want=3", log_q.size()); bad++; end
    foreach (exp_q[k]) if (k < log_q.size()) begin
      total++; if (log_q[k] !== exp_q[k]) begin $display("FAIL err_txn[%0d] got=%h want=%h", k, log_q[k], exp_q[k]); bad++; end
    end
    total++; if (err !== 1'b1 || done_cnt != 1) begin $display("FAIL err_flag got=%b/%0d want=1/1", err, done_cnt); bad++; end
    err_at = -1;
    build_exp(12'h050, 32'h4000_1000, 1, -1);
    run_xfer(12'h050, 32'h4000_1000, 12'd1, -1, fc, da);
    total++; if (err !== 1'b0) begin $display("FAIL err_clear got=%b want=0", err); bad++; end
    total++; if (log_q.size() != 2) begin $display("FAIL err_after_count got=%0d want=2", log_q.size()); bad++; end
    $display("test_bus_err aborted_writes=3 recovered_writes=%0d", log_q.size());
  endtask

  task automatic test_wrap();
    int fc, da;
    stall_cycles = 0; err_at = -1;
    build_exp(12'hFFF, 32'hFFFF_FFF8, 2, -1);
    run_xfer(12'hFFF, 32'hFFFF_FFF8, 12'd2, -1, fc, da);
    total++; if (rd_q.size() != 2) begin $display("FAIL wrap_reads got=%0d want=2", rd_q.size()); bad++; end
    foreach (exp_rd[k]) if (k < rd_q.size()) begin
      total++; if (rd_q[k] !== exp_rd[k]) begin $display("FAIL wrap_raddr[%0d] got=%h want=%h", k, rd_q[k], exp_rd[k]); bad++; end
    end
    total++; if (log_q.size() != 4) begin $display("FAIL wrap_count got=%0d want=4", log_q.size()); bad++; end
    foreach (exp_q[k]) if (k < log_q.size()) begin
      total++; if (log_q[k] !== exp_q[k]) begin $display("FAIL wrap_txn[%0d] got=%h want=%h", k, log_q[k], exp_q[k]); bad++; end
    end
    $display("test_wrap reads=%0d writes=%0d", rd_q.size(), log_q.size());
  endtask

  task automatic test_reset_mid();
    int n, fc, da;
    stall_cycles = 50; err_at = -1;
    @(negedge clk);
    src_addr = 12'h200; dst_addr = 32'h5000_0000; len = 12'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(icb_cmd_valid && icb_cmd_addr == 32'h5000_0004) && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++; if (n >= 500) begin $display("FAIL midrst_reach got=timeout want=cmd_hi"); bad++; end
    #2 rst_n = 1'b0;
    #1;
    total++; if (icb_cmd_valid !== 1'b0 || busy !== 1'b0 || csbn_sram_output !== 1'b1) begin
      $display("FAIL midrst_async got=v%b/b%b/c%b want=0/0/1", icb_cmd_valid, busy, csbn_sram_output); bad++; end
    @(negedge clk);
    #2 rst_n = 1'b1;
    stall_cycles = 1;
    build_exp(12'h300, 32'h6000_0000, 3, -1);
    run_xfer(12'h300, 32'h6000_0000, 12'd3, 5, fc, da);
    total++; if (log_q.size() != 6) begin $display("FAIL midrst_count got=%0d want=6", log_q.size()); bad++; end
    foreach (exp_q[k]) if (k < log_q.size()) begin
      total++; if (log_q[k] !== exp_q[k]) begin $display("FAIL midrst_txn[%0d] got=%h want=%h", k, log_q[k], exp_q[k]); bad++; end
    end
    total++; if (done_cnt != 1 || busy !== 1'b0) begin $display("FAIL midrst_finish got=%0d/%b want=1/0", done_cnt, busy); bad++; end
    $display("test_reset_mid writes_after_reset=%0d", log_q.size());
  endtask

  task automatic test_random();
    int fc, da, l;
    logic [11:0] s;
    logic [31:0] d;
    for (int it = 0; it < 6; it++) begin
      l = $urandom_range(1, 4);
      s = 12'($urandom);
      d = $urandom & 32'hFFFF_FFF8;
      stall_cycles = $urandom_range(0, 3);
      err_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2 * l - 1) : -1;
      build_exp(s, d, l, err_at);
      run_xfer(s, d, 12'(l), -1, fc, da);
      total++; if (log_q.size() != exp_q.size()) begin
        $display("FAIL rand%0d_count got=%0d want=%0d", it, log_q.size(), exp_q.size()); bad++; end
      foreach (exp_q[k]) if (k < log_q.size()) begin
        total++; if (log_q[k] !== exp_q[k]) begin $display("FAIL rand%0d_txn[%0d] got=%h want=%h", it, k, log_q[k], exp_q[k]); bad++; end
      end
      total++; if (err !== exp_err || done_cnt != 1 || proto_err != 0) begin
        $display("FAIL rand%0d_status got=err%b/done%0d/proto%0d want=err%b/done1/proto0", it, err, done_cnt, proto_err, exp_err); bad++; end
      if (err_at < 0) begin
        total++; if (da != (6 + 2 * stall_cycles) * l + 1) begin
          $display("FAIL rand%0d_latency got=%0d want=%0d", it, da, (6 + 2 * stall_cycles) * l + 1); bad++; end
      end
      $display("test_random it=%0d len=%0d stall=%0d err_at=%0d writes=%0d", it, l, stall_cycles, err_at, log_q.size());
    end
  endtask

  initial begin
    icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0; icb_rsp_rdata = '0;
    rdata_sram_output = '0;
    for (int i = 0; i < 4096; i++) sram[i] = {$urandom, $urandom};
    test_reset();
    test_single();
    test_stall();
    test_zero_len();
    test_bus_err();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
